// File: rtl/top_level_cipher.sv
// LFSR stream-cipher engine with internal 256-byte data memory.
// Runs one of three hardwired programs (encrypt / decrypt / decrypt-and-strip) per init release.

module cipher_dm (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] DM [0:255];

    always_ff @(posedge clk) begin
        if (we) DM[waddr] <= wdata;
    end

    assign rdata = DM[raddr];
endmodule

module top_level_cipher (
    input  logic clk,
    input  logic init,
    output logic done
);
    typedef enum logic [2:0] {IDLE, PARAM, KEY, TAPSRCH, SCAN, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [1:0] prog;
    logic [7:0] plen, tap, lfsr;
    logic [6:0] cnt, base;
    logic [7:0] key [0:8];
    logic       found;

    logic       mem_we;
    logic [7:0] waddr, wdata, raddr, rdata;

    logic [7:0] cnt8, pad_src, dec, cand, tap_fin;
    logic [6:0] run_idx;
    logic       in_pad, run_ok, cand_ok;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input logic [7:0] t,
                                            input logic [6:0] n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < 64; i++)
            if (7'(i) < n) v = lfsr_step(v, t);
        return v;
    endfunction

    function automatic logic [7:0] cand_tap(input logic [2:0] c);
        case (c)
            3'd0:    return 8'he1;
            3'd1:    return 8'hd4;
            3'd2:    return 8'hc6;
            3'd3:    return 8'hb8;
            3'd4:    return 8'hb4;
            3'd5:    return 8'hb2;
            3'd6:    return 8'hfa;
            default: return 8'hf3;
        endcase
    endfunction

    cipher_dm data_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign cnt8    = {1'b0, cnt};
    assign in_pad  = (cnt8 >= plen) && (cnt8 < plen + 8'd41);
    assign pad_src = cnt8 - plen;
    assign dec     = rdata ^ lfsr;
    assign run_idx = base + cnt;
    assign run_ok  = run_idx < 7'd64;
    assign cand    = cand_tap(cnt[2:0]);
    assign tap_fin = found ? tap : (cand_ok ? cand : 8'he1);

    // A candidate tap is accepted only if it reproduces all eight recovered key transitions.
    always_comb begin
        cand_ok = 1'b1;
        for (int i = 0; i < 8; i++)
            if (lfsr_step(key[i], cand) != key[i+1]) cand_ok = 1'b0;
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        waddr    = 8'd0;
        wdata    = 8'd0;
        raddr    = 8'd0;
        case (state)
            IDLE: begin
                raddr    = 8'd128;
                state_nx = PARAM;
            end
            PARAM: begin
                raddr = 8'd41 + {6'd0, cnt[1:0]};
                if (prog == 2'd0)      state_nx = DONE;
                else if (cnt == 7'd2)  state_nx = (prog == 2'd1) ? RUN : KEY;
            end
            KEY: begin
                raddr = 8'd64 + cnt8;
                if (cnt == 7'd8) state_nx = TAPSRCH;
            end
            TAPSRCH: begin
                if (cnt == 7'd7) state_nx = (prog == 2'd3) ? SCAN : RUN;
            end
            SCAN: begin
                raddr = 8'd64 + cnt8;
                if (dec != 8'h20 || cnt == 7'd63) state_nx = RUN;
            end
            RUN: begin
                mem_we = 1'b1;
                if (prog == 2'd1) begin
                    raddr = pad_src;
                    waddr = 8'd64 + cnt8;
                    wdata = (in_pad ? rdata : 8'h20) ^ lfsr;
                    if (cnt == 7'd63) state_nx = DONE;
                end else begin
                    raddr = 8'd64 + {1'b0, run_idx};
                    waddr = cnt8;
                    wdata = run_ok ? dec : 8'h20;
                    if (cnt == 7'd40) state_nx = DONE;
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            prog  <= 2'd0;
            plen  <= 8'd0;
            tap   <= 8'd0;
            lfsr  <= 8'd0;
            cnt   <= 7'd0;
            base  <= 7'd0;
            found <= 1'b0;
            for (int i = 0; i < 9; i++) key[i] <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    prog <= (rdata == 8'd1 || rdata == 8'd2 || rdata == 8'd3) ? rdata[1:0] : 2'd0;
                    cnt  <= 7'd0;
                end
                PARAM: begin
                    case (cnt[1:0])
                        2'd0:    plen <= rdata;
                        2'd1:    tap  <= rdata;
                        default: lfsr <= rdata;
                    endcase
                    cnt <= (cnt == 7'd2) ? 7'd0 : cnt + 7'd1;
                end
                KEY: begin
                    key[cnt[3:0]] <= rdata ^ 8'h20;
                    cnt   <= (cnt == 7'd8) ? 7'd0 : cnt + 7'd1;
                    found <= 1'b0;
                end
                TAPSRCH: begin
                    if (!found && cand_ok) begin
                        tap   <= cand;
                        found <= 1'b1;
                    end
                    cnt <= cnt + 7'd1;
                    if (cnt == 7'd7) begin
                        cnt  <= 7'd0;
                        tap  <= tap_fin;
                        // Program 2 knows its start index, so jump the keystream straight there.
                        lfsr <= (prog == 2'd2) ? lfsr_adv(key[0], tap_fin, plen[6:0]) : key[0];
                        base <= (prog == 2'd2) ? plen[6:0] : 7'd0;
                    end
                end
                SCAN: begin
                    if (dec != 8'h20) begin
                        base <= cnt;
                        cnt  <= 7'd0;
                    end else begin
                        lfsr <= lfsr_step(lfsr, tap);
                        cnt  <= cnt + 7'd1;
                        if (cnt == 7'd63) begin
                            base <= 7'd64;
                            cnt  <= 7'd0;
                        end
                    end
                end
                RUN: begin
                    lfsr <= lfsr_step(lfsr, tap);
                    cnt  <= cnt + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
endmodule

// File: tb/tb_top_level_cipher.sv
// Self-checking bench for top_level_cipher: preloads memory, runs each program,
// and compares memory against a scoreboard of bytes predicted by a reference model.

module tb_top_level_cipher;
    logic clk;
    logic init;
    logic done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg [0:40];
    logic [7:0] ct  [0:63];

    top_level_cipher dut (
        .clk  (clk),
        .init (init),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    task automatic set_msg(input string s);
        for (int i = 0; i < 41; i++) msg[i] = (i < s.len()) ? s[i] : 8'h20;
    endtask

    task automatic model_encrypt(input int p, input logic [7:0] t, input logic [7:0] seed);
        logic [7:0] s, pad;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            pad   = (i >= p && i < p + 41) ? msg[i-p] : 8'h20;
            ct[i] = pad ^ s;
            s     = step(s, t);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        init = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic stop_run();
        @(negedge clk);
        init = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        init = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
    endtask

    task automatic test_encrypt(input string name, input string text, input int p,
                                input logic [7:0] t, input logic [7:0] seed);
        int   cyc;
        exp_t e;
        set_msg(text);
        model_encrypt(p, t, seed);
        for (int i = 0; i < 41; i++) dut.data_mem.DM[i] = msg[i];
        dut.data_mem.DM[41]  = 8'(p);
        dut.data_mem.DM[42]  = t;
        dut.data_mem.DM[43]  = seed;
        dut.data_mem.DM[128] = 8'd1;
        for (int i = 64; i < 128; i++) dut.data_mem.DM[i] = 8'h00;
        for (int i = 0; i < 41; i++) exp_q.push_back('{8'(i), msg[i]});
        exp_q.push_back('{8'd41, 8'(p)});
        exp_q.push_back('{8'd42, t});
        exp_q.push_back('{8'd43, seed});
        for (int i = 0; i < 64; i++) exp_q.push_back('{8'(64 + i), ct[i]});
        start_run();
        wait_done(70, cyc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: done=%b after %0d cycles, want 1 within 70", name, done, cyc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut.data_mem.DM[e.addr] !== e.data) begin
                errors++;
                $display("FAIL %s_mem: DM[%0d] got %h want %h", name, e.addr, dut.data_mem.DM[e.addr], e.data);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_held: got %b want 1", name, done);
        end
        stop_run();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_clear: got %b want 0", name, done);
        end
    endtask

    task automatic test_decrypt(input string name, input logic [7:0] sel, input int p,
                                input logic [7:0] t, input logic [7:0] seed,
                                input string want);
        int   cyc;
        exp_t e;
        model_encrypt(p, t, seed);
        for (int i = 0; i < 41; i++) dut.data_mem.DM[i] = 8'h00;
        dut.data_mem.DM[41]  = 8'(p);
        dut.data_mem.DM[42]  = 8'h00;
        dut.data_mem.DM[43]  = 8'h00;
        dut.data_mem.DM[128] = sel;
        for (int i = 0; i < 64; i++) dut.data_mem.DM[64 + i] = ct[i];
        set_msg(want);
        for (int i = 0; i < 41; i++) exp_q.push_back('{8'(i), msg[i]});
        start_run();
        wait_done(200, cyc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: done=%b after %0d cycles, want 1 within 200", name, done, cyc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut.data_mem.DM[e.addr] !== e.data) begin
                errors++;
                $display("FAIL %s_mem: DM[%0d] got %h want %h", name, e.addr, dut.data_mem.DM[e.addr], e.data);
            end
        end
        stop_run();
    endtask

    task automatic test_midrun_reset();
        int cyc;
        set_msg("Mr. Watson, come here. I want to see you.");
        model_encrypt(9, 8'hd4, 8'h64);
        for (int i = 0; i < 41; i++) dut.data_mem.DM[i] = msg[i];
        dut.data_mem.DM[41]  = 8'd9;
        dut.data_mem.DM[42]  = 8'hd4;
        dut.data_mem.DM[43]  = 8'h64;
        dut.data_mem.DM[128] = 8'd1;
        for (int i = 64; i < 128; i++) dut.data_mem.DM[i] = 8'haa;
        start_run();
        wait_done(20, cyc);
        #2;
        init = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_done: got %b want 0", done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (dut.data_mem.DM[64] !== ct[0]) begin
            errors++;
            $display("FAIL midrun_kept: DM[64] got %h want %h", dut.data_mem.DM[64], ct[0]);
        end
        checks++;
        if (dut.data_mem.DM[127] !== 8'haa) begin
            errors++;
            $display("FAIL midrun_untouched: DM[127] got %h want aa", dut.data_mem.DM[127]);
        end
    endtask

    task automatic test_bad_select(input logic [7:0] sel);
        int cyc;
        int bad;
        for (int i = 0; i < 128; i++) dut.data_mem.DM[i] = 8'(i * 7 + 3);
        dut.data_mem.DM[128] = sel;
        start_run();
        wait_done(3, cyc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bad_sel_%0d_done: done=%b after %0d cycles, want 1 within 3", sel, done, cyc);
        end
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (dut.data_mem.DM[i] !== 8'(i * 7 + 3)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bad_sel_%0d_nowrite: %0d bytes changed, want 0", sel, bad);
        end
        stop_run();
    endtask

    initial begin
        string p3;
        init = 1'b0;
        test_reset();
        repeat (2) @(negedge clk);

        test_encrypt("enc_p9", "Mr. Watson, come here. I want to see you.", 9, 8'hd4, 8'h64);
        checks++;
        if (ct[0] !== 8'h44) begin
            errors++;
            $display("FAIL enc_model_first: got %h want 44", ct[0]);
        end
        test_encrypt("enc_p11", "Mr. Watson, come here. I want to see you.", 11, 8'hb2, 8'h19);

        set_msg("Knowledge comes, but wisdom lingers.     ");
        test_decrypt("dec_p2", 8'd2, 9, 8'hb4, 8'h21, "Knowledge comes, but wisdom lingers.     ");

        p3 = "";
        for (int i = 0; i < 27; i++) p3 = {p3, " "};
        p3 = {p3, "Ajok"};
        for (int i = 0; i < 10; i++) p3 = {p3, " "};
        set_msg(p3);
        test_decrypt("dec_p3", 8'd3, 10, 8'hfa, 8'h0d, "Ajok");

        test_midrun_reset();
        test_bad_select(8'd0);
        test_bad_select(8'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
